// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_supervisor
//  Purpose  : Reset and lock supervisor for the system PLL, clocked by the
//             PLL reference clock. Pulses the PLL reset, waits for a
//             synchronized lock indication, and retries the PLL if it does
//             not lock within a timeout. Downstream logic stays in reset
//             until lock has been continuously high for a programmable
//             window. Lock losses while running are counted.
//  Ports    : refclk      in   reference clock (only clock)
//             rst_n       in   asynchronous active-low reset
//             soft_rst    in   synchronous request to restart the sequence
//             pll_locked  in   PLL lock, asynchronous to refclk
//             pll_rst     out  PLL reset, active high, registered
//             sys_reset   out  downstream reset, active high, registered
//             ready       out  locked and stable (always ~sys_reset)
//             timeout_err out  sticky: a lock timeout has occurred
//             relock_cnt  out  lock losses seen while running, saturating
//  Revision : 1.0  initial release
// ============================================================================
module pll_lock_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       soft_rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic       timeout_err,
   output logic [7:0] relock_cnt
);

   // One shared down-counter, wide enough for the longest of the three
   // intervals. A width of at least 1 keeps degenerate parameters legal.
   localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RESET     = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             sync_meta;
   logic             locked_s;

   // Two-flop synchronizer; only locked_s is used beyond this point.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         sync_meta <= pll_locked;
         locked_s  <= sync_meta;
      end
   end

   // Sequencer. Outputs are registered alongside the state transition that
   // produces them, so they always reflect the state being entered.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RESET;
         cnt         <= RST_LOAD;
         pll_rst     <= 1'b1;
         sys_reset   <= 1'b1;
         ready       <= 1'b0;
         timeout_err <= 1'b0;
         relock_cnt  <= 8'd0;
      end else if (soft_rst) begin
         // Takes priority over a simultaneous lock loss: no count increment.
         state       <= ST_RESET;
         cnt         <= RST_LOAD;
         pll_rst     <= 1'b1;
         sys_reset   <= 1'b1;
         ready       <= 1'b0;
         timeout_err <= 1'b0;
         relock_cnt  <= 8'd0;
      end else begin
         case (state)
            ST_RESET: begin
               if (cnt == '0) begin
                  state   <= ST_WAIT_LOCK;
                  cnt     <= LOCK_LOAD;
                  pll_rst <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_WAIT_LOCK: begin
               // Lock is tested first so a lock arriving on the final
               // timeout cycle is accepted rather than flagged.
               if (locked_s) begin
                  state <= ST_STABLE;
                  cnt   <= STABLE_LOAD;
               end else if (cnt == '0) begin
                  state       <= ST_RESET;
                  cnt         <= RST_LOAD;
                  pll_rst     <= 1'b1;
                  timeout_err <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_STABLE: begin
               // Any dropout restarts with a fresh lock timeout, without
               // re-pulsing the PLL reset.
               if (!locked_s) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= LOCK_LOAD;
               end else if (cnt == '0) begin
                  state     <= ST_RUN;
                  sys_reset <= 1'b0;
                  ready     <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state     <= ST_RESET;
                  cnt       <= RST_LOAD;
                  pll_rst   <= 1'b1;
                  sys_reset <= 1'b1;
                  ready     <= 1'b0;
                  if (relock_cnt != 8'hFF) begin
                     relock_cnt <= relock_cnt + 8'd1;
                  end
               end
            end
            default: begin
               state     <= ST_RESET;
               cnt       <= RST_LOAD;
               pll_rst   <= 1'b1;
               sys_reset <= 1'b1;
               ready     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
